// File: rtl/sme_feeder.sv
// sme_feeder: parses newline-terminated S/P byte records and bursts them gap-free into the SME, then returns its result.
// Build option SME_FEEDER_LOWERCASE_EN folds A-Z to a-z as record payload is captured.
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       err,
  output logic       busy
);
  localparam int SW = $clog2(STR_MAX + 1);
  localparam int PW = $clog2(PAT_MAX + 1);
  localparam int SA = $clog2(STR_MAX);
  localparam int PA = $clog2(PAT_MAX);
  localparam logic [SW-1:0] S_MAX = SW'(STR_MAX);
  localparam logic [PW-1:0] P_MAX = PW'(PAT_MAX);
  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, COLLECT, DROP, EMIT_S, EMIT_P, WAIT_RES} state_t;
  state_t r_state, w_nxt;
  logic [7:0] r_str [STR_MAX];
  logic [7:0] r_pat [PAT_MAX];
  logic [SW-1:0] r_str_len, r_idx;
  logic [PW-1:0] r_pat_len;
  logic [7:0] r_tmo, r_chardata, w_byte;
  logic [4:0] r_res_index;
  logic r_is_pat, r_str_ok, r_str_new;
  logic r_isstring, r_ispattern, r_res_valid, r_res_match, r_err;
  logic w_acc, w_nl, w_full, w_last_s, w_last_p, w_err;
`ifdef SME_FEEDER_LOWERCASE_EN
  assign w_byte = (in_data >= 8'h41 && in_data <= 8'h5A) ? in_data + 8'h20 : in_data;
`else
  assign w_byte = in_data;
`endif
  assign in_ready  = r_state inside {IDLE, COLLECT, DROP};
  assign busy      = r_state inside {EMIT_S, EMIT_P, WAIT_RES};
  assign w_acc     = in_valid && in_ready;
  assign w_nl      = in_data == 8'h0A;
  assign w_full    = r_is_pat ? r_pat_len == P_MAX : r_str_len == S_MAX;
  assign w_last_s  = r_idx == r_str_len - 1'b1;
  assign w_last_p  = r_idx[PW-1:0] == r_pat_len - 1'b1;
  assign chardata  = r_chardata;
  assign isstring  = r_isstring;
  assign ispattern = r_ispattern;
  assign res_valid = r_res_valid;
  assign res_match = r_res_match;
  assign res_index = r_res_index;
  assign err       = r_err;
  always_comb begin
    w_nxt = r_state;
    w_err = 1'b0;
    case (r_state)
      IDLE: if (w_acc) begin
        if (in_data == 8'h53 || in_data == 8'h50) w_nxt = COLLECT;
        else if (!w_nl) begin w_err = 1'b1; w_nxt = DROP; end
      end
      COLLECT: if (w_acc) begin
        if (!w_nl) begin
          if (w_full) begin w_err = 1'b1; w_nxt = DROP; end
        end else if (!r_is_pat) begin
          w_err = r_str_len == '0;
          w_nxt = IDLE;
        end else if (r_pat_len != '0 && r_str_ok) w_nxt = r_str_new ? EMIT_S : EMIT_P;
        else begin w_err = 1'b1; w_nxt = IDLE; end
      end
      DROP:     if (w_acc && w_nl) w_nxt = IDLE;
      EMIT_S:   if (w_last_s) w_nxt = EMIT_P;
      EMIT_P:   if (w_last_p) w_nxt = WAIT_RES;
      WAIT_RES: if (sme_valid) w_nxt = IDLE;
                else if (r_tmo == T_LAST) begin w_err = 1'b1; w_nxt = IDLE; end
      default:  w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (r_state == COLLECT && w_acc && !w_nl && !w_full)
      if (r_is_pat) r_pat[r_pat_len[PA-1:0]] <= w_byte;
      else r_str[r_str_len[SA-1:0]] <= w_byte;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_is_pat    <= 1'b0;
      r_str_ok    <= 1'b0;
      r_str_new   <= 1'b0;
      r_str_len   <= '0;
      r_pat_len   <= '0;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_chardata  <= '0;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_match <= 1'b0;
      r_res_index <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_err       <= w_err;
      r_res_valid <= 1'b0;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      r_chardata  <= '0;
      case (r_state)
        IDLE: if (w_acc) begin
          r_is_pat <= in_data == 8'h50;
          if (in_data == 8'h53) begin r_str_len <= '0; r_str_ok <= 1'b0; end
          if (in_data == 8'h50) r_pat_len <= '0;
        end
        COLLECT: if (w_acc) begin
          r_idx <= '0;
          if (!w_nl && !w_full) begin
            if (r_is_pat) r_pat_len <= r_pat_len + 1'b1;
            else r_str_len <= r_str_len + 1'b1;
          end else if (w_nl && !r_is_pat && r_str_len != '0) begin
            r_str_ok  <= 1'b1;
            r_str_new <= 1'b1;
          end
        end
        EMIT_S: begin
          r_isstring <= 1'b1;
          r_chardata <= r_str[r_idx[SA-1:0]];
          r_idx      <= w_last_s ? '0 : r_idx + 1'b1;
          if (w_last_s) r_str_new <= 1'b0;
        end
        EMIT_P: begin
          r_ispattern <= 1'b1;
          r_chardata  <= r_pat[r_idx[PA-1:0]];
          r_idx       <= r_idx + 1'b1;
          r_tmo       <= '0;
        end
        WAIT_RES: begin
          r_tmo <= r_tmo + 1'b1;
          if (sme_valid) begin
            r_res_valid <= 1'b1;
            r_res_match <= sme_match;
            r_res_index <= sme_match_index;
          end else if (r_tmo == T_LAST) r_str_new <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sme_feeder.sv
// tb_sme_feeder: directed record stimulus with an emit/result scoreboard checked by a negedge monitor.
module tb_sme_feeder;
  logic clk = 0, reset = 1, in_valid = 0, sme_valid = 0, sme_match = 0;
  logic [7:0] in_data = 0;
  logic [4:0] sme_match_index = 0;
  logic in_ready, isstring, ispattern, res_valid, res_match, err, busy;
  logic [7:0] chardata;
  logic [4:0] res_index;
  int n_chk = 0, n_err = 0, n_errp = 0, n_res = 0;
  logic [9:0] sq[$];
  logic [5:0] rq[$];
  logic p_strb = 0, p_err = 0, p_res = 0;
  always #5 clk = ~clk;
  sme_feeder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern), .sme_valid(sme_valid),
    .sme_match(sme_match), .sme_match_index(sme_match_index), .res_valid(res_valid),
    .res_match(res_match), .res_index(res_index), .err(err), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef SME_FEEDER_LOWERCASE_EN
    return (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
`else
    return b;
`endif
  endfunction
  always @(negedge clk) begin
    if (!reset) begin
      if (isstring || ispattern) begin
        chk("strobe_excl", 32'(isstring && ispattern), 0);
        if (sq.size() == 0) chk("extra_strobe", 32'({isstring, ispattern, chardata}), 0);
        else chk("emit", 32'({isstring, ispattern, chardata}), 32'(sq.pop_front()));
      end else begin
        chk("chardata_idle", 32'(chardata), 0);
        if (p_strb && sq.size() != 0) chk("burst_gap", sq.size(), 0);
      end
      if (res_valid) begin
        n_res++;
        if (rq.size() == 0) chk("extra_res", 32'({res_match, res_index}), 32'hFFFF);
        else chk("res", 32'({res_match, res_index}), 32'(rq.pop_front()));
      end
      if (err) n_errp++;
      chk("err_width", 32'(p_err && err), 0);
      chk("res_width", 32'(p_res && res_valid), 0);
    end
    p_strb = isstring || ispattern;
    p_err = err;
    p_res = res_valid;
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    int t = 0;
    in_valid = 1;
    in_data = b;
    while (!in_ready && t < 500) begin @(posedge clk); #1; t++; end
    if (t >= 500) chk("in_ready_wait", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask
  task automatic exp_s(input string s);
    for (int i = 0; i < s.len(); i++) sq.push_back({2'b10, fold(s[i])});
  endtask
  task automatic exp_p(input string s);
    for (int i = 0; i < s.len(); i++) sq.push_back({2'b01, fold(s[i])});
  endtask
  task automatic wait_pat_end();
    bit seen = 0;
    int t = 0;
    while (t < 200) begin
      @(negedge clk);
      t++;
      if (seen && !ispattern) break;
      seen = seen | ispattern;
    end
    chk("pat_end_seen", 32'(seen && !ispattern), 1);
  endtask
  task automatic pulse_res(input logic m, input logic [4:0] idx);
    rq.push_back({m, idx});
    sme_match = m;
    sme_match_index = idx;
    sme_valid = 1;
    @(negedge clk);
    sme_valid = 0;
    chk("res_valid_seen", 32'(res_valid), 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int e0, r0, c, k, t;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_outputs", 32'({isstring, ispattern, res_valid, err, busy, res_match}), 0);
    chk("rst_data", 32'({chardata, res_index}), 0);
    reset = 0;
    // basic string then pattern
    e0 = n_errp;
    send_str("Shello world\n");
    exp_s("hello world");
    exp_p("wor");
    send_str("Pwor\n");
    wait_pat_end();
    pulse_res(1, 5'd6);
    chk("t1_res_fields", 32'({res_match, res_index}), 32'({1'b1, 5'd6}));
    // pattern only, string already loaded
    exp_p("^he");
    send_str("P^he\n");
    chk("t2_in_ready_low", 32'(in_ready), 0);
    chk("t2_busy", 32'(busy), 1);
    wait_pat_end();
    chk("t2_in_ready_wait", 32'(in_ready), 0);
    pulse_res(0, 5'd17);
    chk("t2_in_ready_back", 32'(in_ready), 1);
    idle(2);
    chk("t12_no_err", n_errp - e0, 0);
    // string overflow then orphan pattern
    e0 = n_errp;
    send("S");
    for (int i = 0; i < 33; i++) send("a");
    chk("t3_ovf_err", 32'(err), 1);
    send_str("zz\n");
    send_str("Pab\n");
    idle(3);
    chk("t3_err_count", n_errp - e0, 2);
    // unknown record type and blank line
    e0 = n_errp;
    send_str("Xab\n");
    send_str("\n");
    idle(3);
    chk("t4_err_count", n_errp - e0, 1);
    chk("t4_idle", 32'({in_ready, busy}), 32'b10);
    // timeout, then forced resend with a result on the last cycle
    e0 = n_errp;
    r0 = n_res;
    send_str("SAb\n");
    exp_s("Ab");
    exp_p("xy");
    send_str("Pxy\n");
    wait_pat_end();
    c = 1;
    while (!err && c < 400) begin @(negedge clk); c++; end
    chk("t5_timeout_cycles", c, 255);
    idle(2);
    chk("t5_err_count", n_errp - e0, 1);
    chk("t5_no_res", n_res - r0, 0);
    chk("t5_res_hold", 32'({res_match, res_index}), 32'({1'b0, 5'd17}));
    e0 = n_errp;
    exp_s("Ab");
    exp_p("a");
    send_str("Pa\n");
    wait_pat_end();
    c = 1;
    while (c < 254) begin @(negedge clk); c++; end
    pulse_res(0, 5'd31);
    chk("t5_race_no_err", 32'(err), 0);
    idle(2);
    chk("t5_race_err_count", n_errp - e0, 0);
    // reset in the middle of a string burst
    send_str("Sabcdefgh\n");
    exp_s("abcdefgh");
    exp_p("z");
    send_str("Pz\n");
    k = 0;
    t = 0;
    while (k < 5 && t < 100) begin @(negedge clk); t++; if (isstring) k++; end
    chk("t6_fifth_seen", k, 5);
    #1;
    reset = 1;
    sq.delete();
    @(posedge clk);
    #1;
    chk("t6_strobes_off", 32'({isstring, ispattern}), 0);
    chk("t6_in_ready", 32'(in_ready), 1);
    chk("t6_busy", 32'(busy), 0);
    reset = 0;
    e0 = n_errp;
    send_str("Pa\n");
    idle(3);
    chk("t6_err_after_rst", n_errp - e0, 1);
    idle(5);
    chk("sq_empty", sq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
